// File: rtl/prog_ctr_seq.sv
// Program counter and fetch sequencer: selectable entry points, absolute/relative
// conditional branches, a call/return stack and a Halt/Done handshake.
module prog_ctr_seq #(
    parameter int L     = 10,
    parameter int W     = 8,
    parameter int NPROG = 3,
    parameter int SEL_W = 2,
    parameter int DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [SEL_W-1:0]   ProgSel,
    input  logic [NPROG*L-1:0] StartAddr,
    input  logic               BOE,
    input  logic               IsEqual,
    input  logic               BRel,
    input  logic               Call,
    input  logic               Ret,
    input  logic               Halt,
    input  logic [W-1:0]       Target,
    output logic [L-1:0]       ProgCtr,
    output logic               Running,
    output logic               Done,
    output logic               StackErr
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [L-1:0]      pc_q, pc_d;
    logic [L-1:0]      base_q, base_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              push;
    logic [L-1:0]      stk_q [DEPTH];

    logic [L-1:0]      slot_base, pc_inc, tgt_abs, tgt_rel, stk_top;
    logic signed [W-1:0] tgt_s;
    logic signed [L-1:0] off_s;
    logic [SP_W-1:0]   sp_inc, sp_dec;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              stk_empty, stk_full;

    // Out-of-range ProgSel falls back to slot 0.
    always_comb begin
        slot_base = StartAddr[L-1:0];
        for (int k = 1; k < NPROG; k++) begin
            if (ProgSel == SEL_W'(k)) slot_base = StartAddr[k*L +: L];
        end
    end

    assign tgt_s     = $signed(Target);
    assign off_s     = L'(tgt_s);
    assign tgt_rel   = pc_q + $unsigned(off_s);
    assign tgt_abs   = L'(Target);
    assign pc_inc    = pc_q + L'(1);
    assign sp_inc    = sp_q + SP_W'(1);
    assign sp_dec    = sp_q - SP_W'(1);
    assign push_idx  = sp_q[IDX_W-1:0];
    assign pop_idx   = sp_dec[IDX_W-1:0];
    assign stk_top   = stk_q[pop_idx];
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SP_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        base_d  = base_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
        if (Start) base_d = slot_base;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) state_d = LOAD;
            end
            LOAD: begin
                sp_d  = '0;
                err_d = 1'b0;
                if (Start) begin
                    pc_d = slot_base;
                end else begin
                    pc_d    = base_q + L'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    state_d = LOAD;
                    pc_d    = slot_base;
                end else if (Halt) begin
                    state_d = DONE;
                end else if (Ret) begin
                    if (!stk_empty) begin
                        pc_d = stk_top;
                        sp_d = sp_dec;
                    end else begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end else if (Call) begin
                    if (!stk_full) begin
                        push = 1'b1;
                        pc_d = tgt_abs;
                        sp_d = sp_inc;
                    end else begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end else if (BOE && IsEqual) begin
                    pc_d = BRel ? tgt_rel : tgt_abs;
                end else begin
                    pc_d = pc_inc;
                end
            end
            DONE: begin
                if (Start) begin
                    state_d = LOAD;
                    pc_d    = slot_base;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Return addresses and the latched entry point are data; only control is reset.
    always_ff @(posedge Clk) begin
        base_q <= base_d;
        if (push) stk_q[push_idx] <= pc_inc;
    end

    assign ProgCtr  = pc_q;
    assign Running  = (state_q == RUN);
    assign Done     = (state_q == DONE);
    assign StackErr = err_q;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Table-driven bench for prog_ctr_seq with a queue scoreboard and hand-written
// asynchronous-reset sequences.
module tb_prog_ctr_seq;

    localparam int L     = 10;
    localparam int W     = 8;
    localparam int NPROG = 3;
    localparam int SEL_W = 2;
    localparam int DEPTH = 4;

    localparam logic [6:0] NO  = 7'h00;
    localparam logic [6:0] S   = 7'h01;
    localparam logic [6:0] B   = 7'h02;
    localparam logic [6:0] E   = 7'h04;
    localparam logic [6:0] R   = 7'h08;
    localparam logic [6:0] CL  = 7'h10;
    localparam logic [6:0] RT  = 7'h20;
    localparam logic [6:0] H   = 7'h40;
    localparam logic [6:0] BEQ = 7'h06;

    localparam logic [NPROG*L-1:0] SA_STD  = {10'h200, 10'h100, 10'h000};
    localparam logic [NPROG*L-1:0] SA_WRAP = {10'h200, 10'h3FE, 10'h000};
    localparam logic [NPROG*L-1:0] SA_S0   = {10'h200, 10'h100, 10'h0A0};

    logic               Clk = 1'b0;
    logic               Reset, Start, BOE, IsEqual, BRel, Call, Ret, Halt;
    logic [SEL_W-1:0]   ProgSel;
    logic [NPROG*L-1:0] StartAddr;
    logic [W-1:0]       Target;
    logic [L-1:0]       ProgCtr;
    logic               Running, Done, StackErr;

    prog_ctr_seq #(.L(L), .W(W), .NPROG(NPROG), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .StartAddr(StartAddr),
        .BOE(BOE), .IsEqual(IsEqual), .BRel(BRel), .Call(Call), .Ret(Ret), .Halt(Halt),
        .Target(Target), .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [6:0]         ev;
        logic [SEL_W-1:0]   sel;
        logic [W-1:0]       tgt;
        logic [NPROG*L-1:0] sa;
        logic [L-1:0]       pc;
        logic [2:0]         f;   // {Running, Done, StackErr}
    } vec_t;

    typedef struct {
        logic [L-1:0] pc;
        logic [2:0]   f;
        int           id;
    } exp_t;

    vec_t tab_a[$];
    vec_t tab_b[$];
    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic [6:0] ev, logic [SEL_W-1:0] sel, logic [W-1:0] tgt,
                                logic [NPROG*L-1:0] sa, logic [L-1:0] pc, logic [2:0] f);
        vec_t v;
        v.ev = ev; v.sel = sel; v.tgt = tgt; v.sa = sa; v.pc = pc; v.f = f;
        return v;
    endfunction

    task automatic chk_pc(string name, int id, logic [L-1:0] act, logic [L-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got 0x%0h, want 0x%0h", name, id, act, exp);
        end
    endtask

    task automatic chk_bit(string name, int id, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %b, want %b", name, id, act, exp);
        end
    endtask

    task automatic zero_inputs();
        Start = 1'b0; BOE = 1'b0; IsEqual = 1'b0; BRel = 1'b0;
        Call = 1'b0; Ret = 1'b0; Halt = 1'b0; ProgSel = '0; Target = '0;
    endtask

    task automatic drive(vec_t v, int id);
        exp_t x;
        @(negedge Clk);
        Start     = v.ev[0];
        BOE       = v.ev[1];
        IsEqual   = v.ev[2];
        BRel      = v.ev[3];
        Call      = v.ev[4];
        Ret       = v.ev[5];
        Halt      = v.ev[6];
        ProgSel   = v.sel;
        Target    = v.tgt;
        StartAddr = v.sa;
        x.pc = v.pc; x.f = v.f; x.id = id;
        exp_q.push_back(x);
    endtask

    task automatic chk_reset(int id);
        chk_pc ("rst_pc",   id, ProgCtr,  10'h000);
        chk_bit("rst_run",  id, Running,  1'b0);
        chk_bit("rst_done", id, Done,     1'b0);
        chk_bit("rst_err",  id, StackErr, 1'b0);
    endtask

    // Scoreboard: each driven row is checked just after the following rising edge.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_pc ("pc",   e.id, ProgCtr,  e.pc);
            chk_bit("run",  e.id, Running,  e.f[2]);
            chk_bit("done", e.id, Done,     e.f[1]);
            chk_bit("err",  e.id, StackErr, e.f[0]);
        end
    end

    initial begin
        Reset = 1'b1;
        zero_inputs();
        StartAddr = SA_STD;

        tab_a.push_back(mk(NO,    2'd0, 8'h00, SA_STD,  10'h000, 3'b000));
        tab_a.push_back(mk(S,     2'd1, 8'h00, SA_STD,  10'h000, 3'b000));
        tab_a.push_back(mk(S,     2'd2, 8'h00, SA_STD,  10'h200, 3'b000));
        tab_a.push_back(mk(S,     2'd1, 8'h00, SA_STD,  10'h100, 3'b000));
        tab_a.push_back(mk(NO,    2'd1, 8'h00, SA_STD,  10'h101, 3'b100));
        tab_a.push_back(mk(NO,    2'd0, 8'h00, SA_STD,  10'h102, 3'b100));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'h0E, SA_STD,  10'h110, 3'b100));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'hFC, SA_STD,  10'h10C, 3'b100));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'h04, SA_STD,  10'h110, 3'b100));
        tab_a.push_back(mk(BEQ,   2'd0, 8'h40, SA_STD,  10'h040, 3'b100));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'h7F, SA_STD,  10'h0BF, 3'b100));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'h51, SA_STD,  10'h110, 3'b100));
        tab_a.push_back(mk(B|R,   2'd0, 8'hFC, SA_STD,  10'h111, 3'b100));
        tab_a.push_back(mk(E,     2'd0, 8'h40, SA_STD,  10'h112, 3'b100));
        tab_a.push_back(mk(BEQ,   2'd0, 8'h10, SA_STD,  10'h010, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h20, SA_STD,  10'h020, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h20, SA_STD,  10'h020, 3'b100));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h021, 3'b100));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h011, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h30, SA_STD,  10'h030, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h40, SA_STD,  10'h040, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h50, SA_STD,  10'h050, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h60, SA_STD,  10'h060, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h70, SA_STD,  10'h061, 3'b101));
        tab_a.push_back(mk(NO,    2'd0, 8'h00, SA_STD,  10'h062, 3'b101));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h051, 3'b101));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h041, 3'b101));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h031, 3'b101));
        tab_a.push_back(mk(CL|RT, 2'd0, 8'h77, SA_STD,  10'h012, 3'b101));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h013, 3'b101));
        tab_a.push_back(mk(S,     2'd1, 8'h00, SA_WRAP, 10'h3FE, 3'b001));
        tab_a.push_back(mk(NO,    2'd1, 8'h00, SA_WRAP, 10'h3FF, 3'b100));
        tab_a.push_back(mk(NO,    2'd0, 8'h00, SA_WRAP, 10'h000, 3'b100));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'hFE, SA_WRAP, 10'h3FE, 3'b100));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'h02, SA_WRAP, 10'h000, 3'b100));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_WRAP, 10'h001, 3'b101));
        tab_a.push_back(mk(BEQ,   2'd0, 8'h05, SA_STD,  10'h005, 3'b101));
        tab_a.push_back(mk(H|CL|RT|BEQ, 2'd0, 8'h10, SA_STD, 10'h005, 3'b011));
        tab_a.push_back(mk(CL,    2'd0, 8'h10, SA_STD,  10'h005, 3'b011));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h005, 3'b011));
        tab_a.push_back(mk(BEQ,   2'd0, 8'h40, SA_STD,  10'h005, 3'b011));
        tab_a.push_back(mk(H,     2'd0, 8'h00, SA_STD,  10'h005, 3'b011));
        tab_a.push_back(mk(BEQ|R, 2'd0, 8'hFC, SA_STD,  10'h005, 3'b011));
        tab_a.push_back(mk(S,     2'd2, 8'h00, SA_STD,  10'h200, 3'b001));
        tab_a.push_back(mk(S,     2'd2, 8'h00, SA_STD,  10'h200, 3'b000));
        tab_a.push_back(mk(NO,    2'd2, 8'h00, SA_STD,  10'h201, 3'b100));
        tab_a.push_back(mk(BEQ,   2'd0, 8'h30, SA_STD,  10'h030, 3'b100));
        tab_a.push_back(mk(CL,    2'd0, 8'h50, SA_STD,  10'h050, 3'b100));
        tab_a.push_back(mk(CL|RT, 2'd0, 8'h77, SA_STD,  10'h031, 3'b100));
        tab_a.push_back(mk(RT,    2'd0, 8'h00, SA_STD,  10'h032, 3'b101));
        tab_a.push_back(mk(BEQ,   2'd0, 8'h10, SA_STD,  10'h010, 3'b101));
        tab_a.push_back(mk(CL,    2'd0, 8'h20, SA_STD,  10'h020, 3'b101));
        tab_a.push_back(mk(CL,    2'd0, 8'h24, SA_STD,  10'h024, 3'b101));
        tab_a.push_back(mk(NO,    2'd0, 8'h00, SA_STD,  10'h025, 3'b101));

        tab_b.push_back(mk(S,     2'd3, 8'h00, SA_S0,   10'h000, 3'b000));
        tab_b.push_back(mk(S,     2'd3, 8'h00, SA_S0,   10'h0A0, 3'b000));
        tab_b.push_back(mk(NO,    2'd3, 8'h00, SA_S0,   10'h0A1, 3'b100));
        tab_b.push_back(mk(RT,    2'd0, 8'h00, SA_S0,   10'h0A2, 3'b101));
        tab_b.push_back(mk(S|H,   2'd1, 8'h00, SA_S0,   10'h100, 3'b001));
        tab_b.push_back(mk(NO,    2'd1, 8'h00, SA_S0,   10'h101, 3'b100));

        #2;
        chk_reset(0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < tab_a.size(); i++) drive(tab_a[i], i + 1);

        // Asynchronous reset in the middle of a run, checked before any clock edge.
        @(negedge Clk);
        zero_inputs();
        Reset = 1'b1;
        #1;
        chk_reset(100);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < tab_b.size(); i++) drive(tab_b[i], 200 + i + 1);

        @(posedge Clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
